microstep_hbridge: RTL and testbench
====================================

# microstep_hbridge

Parametrised microstepping dual H-bridge driver, the next generation of `dual_hbridge`. It converts step/dir pulses into a sine/cosine current profile on two bridges: direction pins plus a PWM VREF per phase. Resolution is configurable up to 2^MS_LOG2_MAX microsteps per full step. PWM width is parametric. Idle-current reduction and glitch-free period-aligned duty updates are new. It sits between the motion/step generator and the motor driver pins.

## Interface
- PWM_WIDTH, 8, PWM counter and duty width; period 2^PWM_WIDTH clocks.
- MS_LOG2_MAX, 8, max microsteps per full step = 2^MS_LOG2_MAX; PHASE_BITS = MS_LOG2_MAX+2.
- IDLE_BITS, 20, idle counter width; idle after 2^IDLE_BITS-1 step-free cycles.
- clk  in  1  sole clock.
- resetn  in  1  asynchronous, active-low reset.
- step  in  1  step request, synchronous to clk; rising edge = one microstep.
- dir  in  1  1 = phase increments, 0 = decrements.
- enable  in  1  0 = bridge off, steps ignored.
- brake  in  1  1 = all four phase pins high (enable must be 1).
- microstep_log2  in  4  log2 microsteps per full step; values > MS_LOG2_MAX clamp.
- current  in  8  run current scale, 255 ≈ full scale.
- idle_current  in  8  current scale used while idle.
- phase_a1, phase_a2, phase_b1, phase_b2  out  1 each  bridge direction pins.
- vref_a, vref_b  out  1 each  PWM current reference.
- idle  out  1  idle-current mode active.
- electrical_phase  out  PHASE_BITS  current electrical position.

## Operation
- Step accept: step registered; accept = step & ~step_q & enable & ~brake.
- On accept, phase ± inc mod 2^PHASE_BITS, with inc = 1 << (MS_LOG2_MAX − min(microstep_log2, MS_LOG2_MAX)).
- Changing microstep_log2 does not realign phase.
- Quadrant q = phase[top 2]; i = phase[MS_LOG2_MAX-1:0]; N = 2^MS_LOG2_MAX.
- LUT: lut(k) = round((2^PWM_WIDTH−1)·sin(π/2·k/N)), k = 0..N (N+1 entries).
- Channel A magnitude: lut(i) for q = 0, 2; lut(N−i) for q = 1, 3. Sign positive for q = 0, 1.
- Channel B magnitude: lut(N−i) for q = 0, 2; lut(i) for q = 1, 3. Sign positive for q = 0, 3.
- Duty = (mag · cur) >> 8, truncated to PWM_WIDTH. cur = idle ? idle_current : current.
- Pins: positive sign → x1 = 1, x2 = 0; negative sign → x1 = 0, x2 = 1.
- Zero magnitude keeps the sign; duty is 0.
- PWM: free-running counter; vref_x <= (pwm_cnt < duty_active_x).
- Duty 0 means never high. Maximum is (2^PWM_WIDTH−1)/2^PWM_WIDTH.
- Idle counter: cleared on accept; otherwise increments and saturates. idle = counter saturated.
- Disable (enable = 0): all phase and vref outputs low. Phase, idle counter and PWM counter keep running state; steps are ignored.
- Brake (enable = 1, brake = 1): all four phase pins high. vref duty = ((2^PWM_WIDTH−1) · cur) >> 8. Steps are ignored.
- Priority: disable > brake > normal.

## Timing
- Reset: all pin outputs 0, idle 0, electrical_phase 0, PWM counter 0, duties 0.
- Accept at edge t → electrical_phase updated at t+1 → LUT magnitudes and signs registered t+2 → pending duty and sign registered t+3.
- Pending duty and sign copy to active only on the PWM wrap cycle (pwm_cnt = all ones). Duty never changes mid-period. Worst-case step-to-pin latency is 3 + 2^PWM_WIDTH + 1 cycles.
- Idle entry or exit changes cur; the new duty follows the same pipeline and wrap rule.
- enable and brake are registered and override outputs on the next clock, independent of wrap.
- On release, pins resume from the active registers.
- A step edge that arrives while disabled is consumed, not deferred.
- Reset asserted mid-operation clears everything asynchronously; there is no partial state.

## Structure
- Package `hbridge_pkg`: PHASE_BITS derivation, quadrant encoding constants, output-mode enum (OFF, BRAKE, DRIVE).
- Sub-module `sine_quarter_lut`: registered ROM, N+1 entries, PWM_WIDTH wide, contents generated from parameters at elaboration. Two read ports (A and B indices).

## Test plan
All scenarios use PWM_WIDTH = 8 and MS_LOG2_MAX = 8 (IDLE_BITS = 4 where noted).
- Reset: hold resetn = 0 → all pins 0, idle 0, electrical_phase 0. Release → vref_a/b stay 0.
- microstep_log2 = 8, dir = 1, current = 255, 64 steps → electrical_phase = 64. After the next wrap, dutyA = 97, dutyB = 235; a1 = b1 = 1. Verify vref high counts 97 and 235 per 256 cycles.
- From 0: microstep_log2 = 0, dir = 0, current = 128, one step → phase = 768. After wrap, a2 = 1, a1 = 0, b1 = 1; vref_a high 127/256, vref_b always 0.
- IDLE_BITS = 4, current = 200, idle_current = 50, at phase 256 → after 15 step-free cycles idle = 1; vref_a duty 49 from the next wrap. A step clears idle at the next cycle.
- enable = 0 mid-period → all outputs 0 the next cycle. 5 steps leave electrical_phase unchanged. enable = 1 → prior pattern resumes.
- brake = 1, current = 255 → all four pins 1 the next cycle, vref duty 254. A step is ignored. microstep_log2 = 12 with brake = 0 → one step advances the phase by 1.

Source files
------------

// File: rtl/hbridge_pkg.sv
// hbridge_pkg: shared phase-width helper, quadrant codes and bridge output modes
package hbridge_pkg;
  localparam logic [1:0] QUAD_0 = 2'd0;
  localparam logic [1:0] QUAD_1 = 2'd1;
  localparam logic [1:0] QUAD_2 = 2'd2;
  localparam logic [1:0] QUAD_3 = 2'd3;
  typedef enum logic [1:0] {MODE_OFF, MODE_BRAKE, MODE_DRIVE} mode_t;
  function automatic int phase_bits(input int ms_log2_max);
    return ms_log2_max + 2;
  endfunction
endpackage

// File: rtl/sine_quarter_lut.sv
// sine_quarter_lut: registered dual-port quarter-wave sine ROM, N+1 entries built at elaboration
module sine_quarter_lut #(
  parameter int PWM_WIDTH = 8,
  parameter int MS_LOG2_MAX = 8
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic [MS_LOG2_MAX:0]   idx_a,
  input  logic [MS_LOG2_MAX:0]   idx_b,
  output logic [PWM_WIDTH-1:0]   mag_a,
  output logic [PWM_WIDTH-1:0]   mag_b
);
  localparam int N = 1 << MS_LOG2_MAX;
  logic [PWM_WIDTH-1:0] rom [0:N];
  function automatic logic [PWM_WIDTH-1:0] lut_val(input int k);
    real s;
    s = $sin(3.141592653589793 * real'(k) / (2.0 * real'(N)));
    return PWM_WIDTH'($rtoi(s * real'((1 << PWM_WIDTH) - 1) + 0.5));
  endfunction
  for (genvar k = 0; k <= N; k++) begin : g_rom
    assign rom[k] = lut_val(k);
  end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      mag_a <= '0;
      mag_b <= '0;
    end else begin
      mag_a <= rom[idx_a];
      mag_b <= rom[idx_b];
    end
endmodule

// File: rtl/microstep_hbridge.sv
// microstep_hbridge: step/dir to sine/cosine microstepping dual H-bridge with wrap-aligned PWM
module microstep_hbridge
  import hbridge_pkg::*;
#(
  parameter int PWM_WIDTH = 8,
  parameter int MS_LOG2_MAX = 8,
  parameter int IDLE_BITS = 20,
  localparam int PHASE_BITS = phase_bits(MS_LOG2_MAX)
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  step,
  input  logic                  dir,
  input  logic                  enable,
  input  logic                  brake,
  input  logic [3:0]            microstep_log2,
  input  logic [7:0]            current,
  input  logic [7:0]            idle_current,
  output logic                  phase_a1,
  output logic                  phase_a2,
  output logic                  phase_b1,
  output logic                  phase_b2,
  output logic                  vref_a,
  output logic                  vref_b,
  output logic                  idle,
  output logic [PHASE_BITS-1:0] electrical_phase
);
  localparam logic [MS_LOG2_MAX:0] FULL = {1'b1, {MS_LOG2_MAX{1'b0}}};
  logic step_r, step_q, en_r, brk_r, accept, wrap, odd;
  logic sa_l, sb_l, sa_p, sb_p, sa, sb, vref_a_r, vref_b_r;
  logic [PWM_WIDTH-1:0] pwm_cnt, mag_a, mag_b, pend_a, pend_b, duty_a, duty_b, brake_duty, lim_a, lim_b;
  logic [IDLE_BITS-1:0] idle_cnt;
  logic [MS_LOG2_MAX:0] i_ext, idx_a, idx_b;
  logic [PHASE_BITS-1:0] inc;
  logic [1:0] q;
  logic [7:0] cur;
  int ms_c;
  mode_t mode;
  function automatic logic [PWM_WIDTH-1:0] scale(input logic [PWM_WIDTH-1:0] m, input logic [7:0] c);
    logic [PWM_WIDTH+7:0] p;
    p = {8'b0, m} * {{PWM_WIDTH{1'b0}}, c};
    return p[PWM_WIDTH+7:8];
  endfunction
  always_comb begin
    idle = &idle_cnt;
    cur = idle ? idle_current : current;
    accept = step_r & ~step_q & en_r & ~brk_r;
    wrap = &pwm_cnt;
    ms_c = (int'(microstep_log2) > MS_LOG2_MAX) ? MS_LOG2_MAX : int'(microstep_log2);
    inc = PHASE_BITS'(1) << (MS_LOG2_MAX - ms_c);
    q = electrical_phase[PHASE_BITS-1 -: 2];
    odd = (q == QUAD_1) | (q == QUAD_3);
    i_ext = {1'b0, electrical_phase[MS_LOG2_MAX-1:0]};
    idx_a = odd ? FULL - i_ext : i_ext;
    idx_b = odd ? i_ext : FULL - i_ext;
    brake_duty = scale({PWM_WIDTH{1'b1}}, cur);
    lim_a = brk_r ? brake_duty : duty_a;
    lim_b = brk_r ? brake_duty : duty_b;
    mode = ~en_r ? MODE_OFF : brk_r ? MODE_BRAKE : MODE_DRIVE;
    phase_a1 = (mode == MODE_BRAKE) | ((mode == MODE_DRIVE) & sa);
    phase_a2 = (mode == MODE_BRAKE) | ((mode == MODE_DRIVE) & ~sa);
    phase_b1 = (mode == MODE_BRAKE) | ((mode == MODE_DRIVE) & sb);
    phase_b2 = (mode == MODE_BRAKE) | ((mode == MODE_DRIVE) & ~sb);
    vref_a = (mode != MODE_OFF) & vref_a_r;
    vref_b = (mode != MODE_OFF) & vref_b_r;
  end
  sine_quarter_lut #(.PWM_WIDTH(PWM_WIDTH), .MS_LOG2_MAX(MS_LOG2_MAX)) u_lut (
    .clk(clk), .resetn(resetn), .idx_a(idx_a), .idx_b(idx_b), .mag_a(mag_a), .mag_b(mag_b)
  );
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      {step_r, step_q, en_r, brk_r, vref_a_r, vref_b_r} <= '0;
      {sa_l, sb_l, sa_p, sb_p, sa, sb} <= '1;
      pwm_cnt <= '0;
      idle_cnt <= '0;
      electrical_phase <= '0;
      {pend_a, pend_b, duty_a, duty_b} <= '0;
    end else begin
      step_r <= step;
      step_q <= step_r;
      en_r <= enable;
      brk_r <= brake;
      pwm_cnt <= pwm_cnt + 1'b1;
      if (accept) electrical_phase <= dir ? electrical_phase + inc : electrical_phase - inc;
      idle_cnt <= accept ? '0 : idle ? idle_cnt : idle_cnt + 1'b1;
      sa_l <= (q == QUAD_0) | (q == QUAD_1);
      sb_l <= (q == QUAD_0) | (q == QUAD_3);
      pend_a <= scale(mag_a, cur);
      pend_b <= scale(mag_b, cur);
      sa_p <= sa_l;
      sb_p <= sb_l;
      // active duty/sign only move at the period boundary so a PWM period is never torn
      if (wrap) begin
        duty_a <= pend_a;
        duty_b <= pend_b;
        sa <= sa_p;
        sb <= sb_p;
      end
      vref_a_r <= pwm_cnt < lim_a;
      vref_b_r <= pwm_cnt < lim_b;
    end
endmodule

// File: tb/tb_microstep_hbridge.sv
// tb_microstep_hbridge: randomized and directed checks against a sine-table reference model
module tb_microstep_hbridge;
  logic clk = 0, resetn = 0, step = 0, dir = 0, enable = 0, brake = 0;
  logic [3:0] ms = 0;
  logic [7:0] current = 0, idle_current = 0;
  logic a1, a2, b1, b2, va, vb, idle;
  logic [9:0] ephase;
  int n_chk = 0, n_pass = 0, m_phase = 0, ca, cb;

  microstep_hbridge #(.PWM_WIDTH(8), .MS_LOG2_MAX(8), .IDLE_BITS(4)) dut (
    .clk(clk), .resetn(resetn), .step(step), .dir(dir), .enable(enable), .brake(brake),
    .microstep_log2(ms), .current(current), .idle_current(idle_current),
    .phase_a1(a1), .phase_a2(a2), .phase_b1(b1), .phase_b2(b2),
    .vref_a(va), .vref_b(vb), .idle(idle), .electrical_phase(ephase)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic int lut(input int k);
    return int'($floor(255.0 * $sin(3.141592653589793 * real'(k) / 512.0) + 0.5));
  endfunction

  task automatic pulse(input int n);
    int inc;
    for (int s = 0; s < n; s++) begin
      step = 1;
      tick(2);
      step = 0;
      tick(2);
      inc = 1 << (8 - ((ms > 8) ? 8 : int'(ms)));
      if (enable && !brake) m_phase = (m_phase + (dir ? inc : -inc) + 1024) % 1024;
    end
  endtask

  task automatic count_vref(input int n, output int na, output int nb);
    na = 0;
    nb = 0;
    for (int c = 0; c < n; c++) begin
      tick(1);
      na += int'(va);
      nb += int'(vb);
    end
  endtask

  task automatic measure(input string tag, input int cur, output int na, output int nb);
    int q, i, mag_a, mag_b, pa, pb;
    q = m_phase / 256;
    i = m_phase % 256;
    mag_a = (q % 2 == 0) ? lut(i) : lut(256 - i);
    mag_b = (q % 2 == 0) ? lut(256 - i) : lut(i);
    pa = (q < 2) ? 1 : 0;
    pb = (q == 0 || q == 3) ? 1 : 0;
    tick(280);
    check({tag, ".phase"}, int'(ephase), m_phase);
    check({tag, ".pins"}, int'({a1, a2, b1, b2}), pa * 8 + (1 - pa) * 4 + pb * 2 + (1 - pb));
    count_vref(256, na, nb);
    check({tag, ".duty_a"}, na, (mag_a * cur) / 256);
    check({tag, ".duty_b"}, nb, (mag_b * cur) / 256);
  endtask

  initial begin
    enable = 1;
    tick(3);
    check("rst.outs", int'({a1, a2, b1, b2, va, vb, idle}), 0);
    check("rst.phase", int'(ephase), 0);
    resetn = 1;
    count_vref(240, ca, cb);
    check("rst.vref_quiet", ca + cb, 0);

    ms = 8; dir = 1; current = 255; idle_current = 255;
    pulse(64);
    measure("ms8", 255, ca, cb);
    check("ms8.lit_a", ca, 97);
    check("ms8.lit_b", cb, 235);

    resetn = 0; tick(1); resetn = 1; m_phase = 0;
    ms = 0; dir = 0; current = 128; idle_current = 128;
    pulse(1);
    measure("ms0", 128, ca, cb);
    check("ms0.lit_phase", int'(ephase), 768);
    check("ms0.lit_pins", int'({a1, a2, b1}), 3'b011);
    check("ms0.lit_a", ca, 127);
    check("ms0.lit_b", cb, 0);

    dir = 1; current = 200; idle_current = 50;
    pulse(2);
    check("idle.after_step", int'(idle), 0);
    tick(20);
    check("idle.entered", int'(idle), 1);
    measure("idle", 50, ca, cb);
    check("idle.lit_a", ca, 49);
    dir = 0;
    step = 1;
    tick(2);
    check("idle.cleared", int'(idle), 0);
    step = 0;
    tick(2);
    m_phase = 0;
    idle_current = 200;
    measure("idle_exit", 200, ca, cb);

    current = 180; idle_current = 180; ms = 3; dir = 1;
    pulse(3);
    measure("en_pre", 180, ca, cb);
    tick(77);
    enable = 0;
    tick(1);
    check("dis.outs", int'({a1, a2, b1, b2, va, vb}), 0);
    count_vref(20, ca, cb);
    check("dis.vref", ca + cb, 0);
    pulse(5);
    check("dis.phase", int'(ephase), m_phase);
    enable = 1;
    tick(2);
    check("en.resume_a1", int'(a1 | a2), 1);
    measure("en_post", 180, ca, cb);

    current = 255; idle_current = 255;
    brake = 1;
    tick(1);
    check("brk.pins", int'({a1, a2, b1, b2}), 4'b1111);
    tick(2);
    count_vref(256, ca, cb);
    check("brk.vref_a", ca, 254);
    check("brk.vref_b", cb, 254);
    pulse(1);
    check("brk.phase", int'(ephase), m_phase);
    brake = 0; ms = 12; dir = 1;
    tick(2);
    pulse(1);
    check("clamp.phase", int'(ephase), m_phase);
    measure("clamp", 255, ca, cb);

    for (int r = 0; r < 10; r++) begin
      ms = 4'($urandom_range(0, 15));
      dir = 1'($urandom_range(0, 1));
      current = 8'($urandom_range(0, 255));
      idle_current = current;
      pulse($urandom_range(1, 5));
      measure($sformatf("rnd%0d", r), int'(current), ca, cb);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
